lsfr_4bit: RTL and testbench



---
 rtl/lfsr_pkg.sv | 16 +
 rtl/lsfr_4bit.sv | 24 ++
 tb/tb_lsfr_4bit.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/lfsr_pkg.sv
// Shared constants for the 4-bit Fibonacci LFSR (x^4 + x^3 + 1).
// The next-state helper keeps the tap mask and shift direction in one place.
package lfsr_pkg;

  localparam int LFSR_W = 4;
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 4'b1100;
  localparam logic [LFSR_W-1:0] LFSR_RST = 4'b0000;

  // One shift step: tapped bits XOR-reduced into the LSB, register moves toward the MSB.
  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] state);
    logic fb;
    fb = ^(state & LFSR_TAPS);
    return {state[LFSR_W-2:0], fb};
  endfunction

endpackage

// File: rtl/lsfr_4bit.sv
// 4-bit maximal-length LFSR with synchronous seed load; the state register drives out directly.
// 0000 is a fixed point, so a non-zero seed must be loaded to start the sequence.
module lsfr_4bit
  import lfsr_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [LFSR_W-1:0] seed,
  input  logic              sel,
  output logic [LFSR_W-1:0] out
);

  // Reset beats load, load beats shift.
  always_ff @(posedge clk) begin
    if (reset) begin
      out <= LFSR_RST;
    end else if (sel) begin
      out <= seed;
    end else begin
      out <= lfsr_next(out);
    end
  end

endmodule

// File: tb/tb_lsfr_4bit.sv
// Directed bench for lsfr_4bit: reset, load, full-period walks, zero lock, reset priority, continuous load.
// Expected values come from a hand-written sequence table and an independent shift model.
module tb_lsfr_4bit;

  logic       clk;
  logic       reset;
  logic [3:0] seed;
  logic       sel;
  logic [3:0] out;

  int assert_count;
  int fail_count;

  // Hand-derived period-15 sequence starting from 1111.
  logic [3:0] seq_ref [15] = '{4'b1111, 4'b1110, 4'b1100, 4'b1000, 4'b0001,
                               4'b0010, 4'b0100, 4'b1001, 4'b0011, 4'b0110,
                               4'b1101, 4'b1010, 4'b0101, 4'b1011, 4'b0111};

  lsfr_4bit dut (
    .clk  (clk),
    .reset(reset),
    .seed (seed),
    .sel  (sel),
    .out  (out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [3:0] model_next(input logic [3:0] s);
    return {s[2:0], s[3] ^ s[2]};
  endfunction

  // Drive inputs between edges, advance one rising edge, then settle before sampling.
  task automatic apply_stimulus(input logic rst_in, input logic sel_in, input logic [3:0] seed_in);
    reset = rst_in;
    sel   = sel_in;
    seed  = seed_in;
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [3:0] expected);
    assert_count++;
    assert (out === expected)
    else begin
      fail_count++;
      $error("[TB] FAIL %s: out=%b expected=%b", tag, out, expected);
    end
  endtask

  initial begin
    logic [3:0]  model;
    logic [15:0] seen;
    assert_count = 0;
    fail_count   = 0;
    reset = 1'b1;
    sel   = 1'b1;
    seed  = 4'b0000;
    #2;

    // Reset held with sel=1 and seed=0000.
    for (int i = 0; i < 10; i++) begin
      apply_stimulus(1'b1, 1'b1, 4'b0000);
      check_output("reset_hold", 4'b0000);
    end

    // Load 1111 then run 30 shifts against the hand table and the model.
    apply_stimulus(1'b0, 1'b1, 4'b1111);
    check_output("load_1111", 4'b1111);
    model = 4'b1111;
    for (int i = 1; i <= 30; i++) begin
      apply_stimulus(1'b0, 1'b0, 4'b0000);
      model = model_next(model);
      check_output("seq_table", seq_ref[i % 15]);
      check_output("seq_model", model);
    end

    // Every non-zero seed: 15 distinct non-zero states, back to the seed on the 15th shift.
    for (int s = 1; s < 16; s++) begin
      apply_stimulus(1'b0, 1'b1, 4'(s));
      check_output("period_load", 4'(s));
      model = 4'(s);
      seen  = '0;
      seen[s] = 1'b1;
      for (int k = 1; k <= 15; k++) begin
        apply_stimulus(1'b0, 1'b0, 4'b0000);
        model = model_next(model);
        check_output("period_step", model);
        if (k < 15) begin
          assert_count++;
          assert (seen[out] === 1'b0 && out !== 4'b0000)
          else begin
            fail_count++;
            $error("[TB] FAIL period_distinct: seed=%0d step=%0d out=%b expected=unvisited non-zero", s, k, out);
          end
          seen[out] = 1'b1;
        end else begin
          check_output("period_wrap", 4'(s));
        end
      end
    end

    // Zero seed locks the register at 0000.
    apply_stimulus(1'b0, 1'b1, 4'b0000);
    check_output("zero_load", 4'b0000);
    for (int i = 0; i < 20; i++) begin
      apply_stimulus(1'b0, 1'b0, 4'b1111);
      check_output("zero_lock", 4'b0000);
    end

    // Mid-run reset with simultaneous load: reset must win.
    apply_stimulus(1'b0, 1'b1, 4'b1111);
    check_output("mid_load", 4'b1111);
    apply_stimulus(1'b0, 1'b0, 4'b0000);
    apply_stimulus(1'b0, 1'b0, 4'b0000);
    apply_stimulus(1'b0, 1'b0, 4'b0000);
    check_output("mid_shift3", 4'b1000);
    apply_stimulus(1'b1, 1'b1, 4'b1010);
    check_output("reset_over_sel", 4'b0000);
    apply_stimulus(1'b0, 1'b0, 4'b1010);
    check_output("post_reset_idle", 4'b0000);
    apply_stimulus(1'b0, 1'b1, 4'b1010);
    check_output("post_reset_load", 4'b1010);
    apply_stimulus(1'b0, 1'b0, 4'b0000);
    check_output("first_shift_1010", 4'b0101);

    // Continuous load: out follows seed with one cycle of delay, no shifting.
    apply_stimulus(1'b0, 1'b1, 4'b0011);
    check_output("cont_0011", 4'b0011);
    apply_stimulus(1'b0, 1'b1, 4'b0101);
    check_output("cont_0101", 4'b0101);
    apply_stimulus(1'b0, 1'b1, 4'b1001);
    check_output("cont_1001", 4'b1001);
    apply_stimulus(1'b0, 1'b0, 4'b1111);
    check_output("cont_release", 4'b0011);

    $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end

endmodule
